// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and parity helper for the tx and rx paths.
package uart_pkg;

    localparam int SPEED_W = 13;
    localparam int DATA_W  = 8;

    localparam logic [SPEED_W-1:0] DEFAULT_SPEED = 13'h1869;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous DEPTH x DATA_W FIFO feeding the UART transmitter.
// A push while full is dropped even when a pop happens in the same cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; power-of-two depth makes the wrap free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO and a load-strobed 13-bit bit-rate divisor.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int                  DEPTH         = 4,
    parameter logic [SPEED_W-1:0]  DEFAULT_SPEED = uart_pkg::DEFAULT_SPEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                set_speed,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                send,
    output logic                ready,
    output logic                tx,
    output logic                busy,
    output logic                tx_done
);

    state_t               state_r;
    state_t               state_next_s;
    logic [SPEED_W-1:0]   div_r;
    logic [SPEED_W-1:0]   div_next_s;
    logic [SPEED_W-1:0]   baud_r;
    logic [SPEED_W-1:0]   baud_next_s;
    logic [2:0]           bit_idx_r;
    logic [2:0]           bit_idx_next_s;
    logic [DATA_W-1:0]    shift_r;
    logic [DATA_W-1:0]    shift_next_s;
    logic                 tx_r;
    logic                 tx_s;
    logic                 tx_done_r;
    logic                 tx_done_s;
    logic                 pop_s;
    logic                 baud_done_s;
    logic [DATA_W-1:0]    fifo_head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
    logic                 parity_next_s;
`endif

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (send),
        .push_data (data_in),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign ready       = !fifo_full_s;
    assign busy        = (state_r != IDLE) || (fifo_count_s != '0);
    assign tx          = tx_r;
    assign tx_done     = tx_done_r;
    assign baud_done_s = (baud_r == div_r);

    // Next-state, datapath-next and line value; the line is registered one cycle later.
    always_comb begin
        state_next_s   = state_r;
        div_next_s     = div_r;
        baud_next_s    = baud_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        tx_s           = 1'b1;
        tx_done_s      = 1'b0;
        pop_s          = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                tx_s = 1'b1;
                // Rate changes are only honoured between frames.
                if (set_speed) begin
                    div_next_s = speed;
                end else begin
                    div_next_s = div_r;
                end
                if (!fifo_empty_s) begin
                    pop_s          = 1'b1;
                    shift_next_s   = fifo_head_s;
                    baud_next_s    = {SPEED_W{1'b0}};
                    bit_idx_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_next_s  = even_parity(fifo_head_s);
`endif
                    state_next_s   = START;
                end else begin
                    state_next_s   = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (baud_done_s) begin
                    baud_next_s    = {SPEED_W{1'b0}};
                    bit_idx_next_s = 3'd0;
                    state_next_s   = DATA;
                end else begin
                    baud_next_s    = baud_r + SPEED_W'(1);
                end
            end
            DATA: begin
                tx_s = shift_r[0];
                if (baud_done_s) begin
                    baud_next_s  = {SPEED_W{1'b0}};
                    shift_next_s = {1'b0, shift_r[DATA_W-1:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_next_s = baud_r + SPEED_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_s = parity_r;
                if (baud_done_s) begin
                    baud_next_s  = {SPEED_W{1'b0}};
                    state_next_s = STOP;
                end else begin
                    baud_next_s  = baud_r + SPEED_W'(1);
                end
            end
`endif
            STOP: begin
                tx_s = 1'b1;
                if (baud_done_s) begin
                    baud_next_s  = {SPEED_W{1'b0}};
                    tx_done_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    baud_next_s  = baud_r + SPEED_W'(1);
                end
            end
            default: begin
                tx_s         = 1'b1;
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divisor, baud/bit counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_r     <= DEFAULT_SPEED;
            baud_r    <= {SPEED_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= {DATA_W{1'b0}};
            tx_r      <= 1'b1;
            tx_done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            div_r     <= div_next_s;
            baud_r    <= baud_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_s;
            tx_done_r <= tx_done_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (DEPTH=4); frame model follows UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] speed;
    logic        set_speed;
    logic [7:0]  data_in;
    logic        send;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DEPTH         (4),
        .DEFAULT_SPEED (13'h1869)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .speed     (speed),
        .set_speed (set_speed),
        .data_in   (data_in),
        .send      (send),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Expected line level at offset j (clocks) into a frame of byte b at divisor d.
    function automatic logic exp_tx(input logic [7:0] b, input int d, input int j);
        int bi;
        bi = j / (d + 1);
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0; set_speed = 1'b0; send = 1'b0; speed = 13'd0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL reset_tx k=%0d got=%b exp=1", k, tx); end
            checks++; if (ready !== 1'b1)   begin failures++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, ready); end
            checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy); end
            checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done k=%0d got=%b exp=0", k, tx_done); end
        end
    endtask

    task automatic test_single();
        int j; logic et; logic ed;
        @(negedge clk); speed = 13'd3; set_speed = 1'b1;
        @(negedge clk); set_speed = 1'b0; data_in = 8'hA5; send = 1'b1;
        @(negedge clk); send = 1'b0;
        checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready); end
        for (int k = 1; k < 2 + FB*4 + 3; k++) begin
            @(negedge clk);
            j  = k - 2;
            et = (j >= 0 && j < FB*4) ? exp_tx(8'hA5, 3, j) : 1'b1;
            ed = (j == FB*4 - 1);
            checks++; if (tx !== et)      begin failures++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, tx, et); end
            checks++; if (tx_done !== ed) begin failures++; $display("FAIL single_done k=%0d got=%b exp=%b", k, tx_done, ed); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int fl; int j; int f; int o; logic et; logic ed; logic [7:0] b; logic er;
        fl = FB * 2;
        @(negedge clk); speed = 13'd1; set_speed = 1'b1;
        @(negedge clk); set_speed = 1'b0; data_in = 8'h01; send = 1'b1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready push=0 got=%b exp=1", ready); end
        for (int k = 0; k < 2 + 5*(fl+1) + 4; k++) begin
            @(negedge clk);
            if (k < 2) begin
                et = 1'b1; ed = 1'b0;
            end else begin
                j = k - 2; f = j / (fl + 1); o = j % (fl + 1);
                b = 8'(f + 1);
                et = (f < 5 && o < fl) ? exp_tx(b, 1, o) : 1'b1;
                ed = (f < 5 && o == fl - 1);
            end
            checks++; if (tx !== et)      begin failures++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx, et); end
            checks++; if (tx_done !== ed) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, tx_done, ed); end
            if (k + 1 < 7) begin
                data_in = 8'(k + 2); send = 1'b1;
                er = (k + 1 < 5);
                checks++; if (ready !== er) begin failures++; $display("FAIL b2b_ready push=%0d got=%b exp=%b", k+1, ready, er); end
            end else begin
                send = 1'b0;
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_speed_mid();
        int j; logic et; logic ed; logic [7:0] b;
        @(negedge clk); speed = 13'd3; set_speed = 1'b1;
        @(negedge clk); set_speed = 1'b0;
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h55 : 8'h0F;
            data_in = b; send = 1'b1;
            @(negedge clk); send = 1'b0;
            for (int k = 1; k < 2 + FB*4 + 3; k++) begin
                @(negedge clk);
                if (n == 0 && k == 10) begin speed = 13'd7; set_speed = 1'b1; end
                else begin set_speed = 1'b0; end
                j  = k - 2;
                et = (j >= 0 && j < FB*4) ? exp_tx(b, 3, j) : 1'b1;
                ed = (j == FB*4 - 1);
                checks++; if (tx !== et)      begin failures++; $display("FAIL midspd_tx n=%0d k=%0d got=%b exp=%b", n, k, tx, et); end
                checks++; if (tx_done !== ed) begin failures++; $display("FAIL midspd_done n=%0d k=%0d got=%b exp=%b", n, k, tx_done, ed); end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); data_in = 8'hFF; send = 1'b1;
        @(negedge clk); data_in = 8'hAA;
        @(negedge clk); data_in = 8'hBB;
        @(negedge clk); send = 1'b0;
        repeat (16) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1)   begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", tx_done); end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL rstmid_quiet_tx k=%0d got=%b exp=1", k, tx); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_quiet_busy k=%0d got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_speed_zero();
        int j; logic et; logic ed; logic [7:0] b;
        @(negedge clk); speed = 13'd0; set_speed = 1'b1;
        @(negedge clk); set_speed = 1'b0;
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h07 : 8'h03;
            data_in = b; send = 1'b1;
            @(negedge clk); send = 1'b0;
            for (int k = 1; k < 2 + FB + 3; k++) begin
                @(negedge clk);
                j  = k - 2;
                et = (j >= 0 && j < FB) ? exp_tx(b, 0, j) : 1'b1;
                ed = (j == FB - 1);
                checks++; if (tx !== et)      begin failures++; $display("FAIL spd0_tx n=%0d k=%0d got=%b exp=%b", n, k, tx, et); end
                checks++; if (tx_done !== ed) begin failures++; $display("FAIL spd0_done n=%0d k=%0d got=%b exp=%b", n, k, tx_done, ed); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_speed_mid();
        test_reset_mid();
        test_speed_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter with a small TX FIFO; the outbound counterpart to the receive path (uart_rx).
- Bit-rate interface matches the receiver: a 13-bit divisor plus a load strobe, default 13'h1869.
- Sits between the CPU/memory-controller byte source and the top-level tx pin.
- Accepts bytes on a valid/ready handshake and serialises them back-to-back.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DEFAULT_SPEED, 13'h1869, divisor after reset; bit period = DEFAULT_SPEED+1 clocks.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- speed  in  13  new divisor; bit period = speed+1 clocks
- set_speed  in  1  load strobe for speed
- data_in  in  8  byte to transmit
- send  in  1  data_in valid
- ready  out  1  FIFO not full; byte accepted on a cycle where send && ready
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress or FIFO non-empty
- tx_done  out  1  one-cycle pulse at end of each stop bit

Behaviour:
- Reset (reset==0 at a clk edge) gives: tx=1, ready=1, busy=0, tx_done=0, FIFO empty, state IDLE, divisor=DEFAULT_SPEED, bit counter 0, baud counter 0. Reset mid-frame aborts immediately; tx returns high on the next edge and queued bytes are discarded.
- Divisor register: loaded from speed when set_speed=1 and state==IDLE. set_speed in any other state is ignored, not deferred. speed=0 is legal and gives 1 clock/bit.
- FIFO push on send && ready. ready = !full from the registered count. A push while full is dropped even if a pop occurs in the same cycle. A push and a pop in the same non-full cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. If the FIFO is non-empty: pop the head into an 8-bit shift register, clear the baud counter, go to START.
- START: tx=0 for divisor+1 clocks, then go to DATA with bit index 0.
- DATA: tx=shift[0], LSB first. Each bit is held divisor+1 clocks, then shift right. After bit index 7, go to STOP.
- STOP: tx=1 for divisor+1 clocks. On the final clock assert tx_done for 1 cycle and go to IDLE.
- Latency: a push accepted at edge N into an empty, idle FIFO gives tx=0 from edge N+2.
- Frame = 10*(divisor+1) clocks, plus exactly 1 IDLE cycle between back-to-back frames.
- busy = (state!=IDLE) || !empty, combinational from registers.
- The baud counter compares against the latched divisor only; no mid-frame rate change is possible.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for divisor+1 clocks. Frame = 11*(divisor+1) clocks; tx_done still pulses at the end of STOP.
- Undefined: no PARITY state; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DEFAULT_SPEED = 13'h1869;
  - SPEED_W = 13, DATA_W = 8.
  - uart_rx imports the same constants.
- One sub-module, uart_tx_fifo: synchronous DEPTH x 8 FIFO with push, pop, full, empty, count, on the same clk/reset.
- uart_tx holds the FSM, baud counter and shift register.

Test Plan:
- Reset then idle: reset low 3 cycles then high, divisor 13'h1869 -> tx=1, ready=1, busy=0 for 1000 cycles, no tx_done.
- Single byte: set_speed=1 with speed=3 while idle; send 8'hA5 -> tx low 2 cycles after accept. Bits are 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high. tx_done fires at clock 40 of the frame.
- Back-to-back and full: speed=1; push 8'h01..8'h05 on consecutive cycles with DEPTH=4 -> ready drops once the FIFO is full. Every push while ready=0 is dropped. Each accepted byte is transmitted in push order, with exactly 1 idle cycle between stop and the next start.
- set_speed mid-frame: start 8'h55 at speed=3, strobe speed=7 during DATA -> the frame stays at 4 clocks/bit. The next frame also uses 4, since the strobe is not deferred.
- Reset mid-frame: assert reset during bit 3 of 8'hFF with 2 bytes queued -> tx=1, busy=0, ready=1 on the next edge; nothing is transmitted after release.
- UART_TX_PARITY_EN: speed=0; send 8'h07 -> parity bit = 1, frame is 11 clocks. Send 8'h03 -> parity bit = 0.
